// File: rtl/cla8_share_pkg.sv
// cla8_share_pkg: constants and types shared by the cla8 sharing controller
// and its round-robin arbiter.
package cla8_share_pkg;

    localparam int NREQ_MAX = 8;
    localparam int BYTE_W   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/cla8.sv
// cla8: 8-bit carry-lookahead adder. Every carry is written as a flat
// sum of generate/propagate products, so no carry depends on another.
module cla8
    import cla8_share_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] g;
    logic [BYTE_W:0]   c;

    // Expand each carry c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
    always_comb begin
        logic term;
        logic c_next;
        p      = a ^ b;
        g      = a & b;
        c      = '0;
        c[0]   = cin;
        term   = 1'b0;
        c_next = 1'b0;
        // NOTE: combinational temporaries use blocking '=' so each loop step
        // sees the value written just before it; flops elsewhere use '<='.
        for (int i = 0; i < BYTE_W; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            c_next = term;
            for (int k = 0; k <= i; k++) begin
                term = g[k];
                for (int j = k + 1; j <= i; j++) begin
                    term = term & p[j];
                end
                c_next = c_next | term;
            end
            c[i+1] = c_next;
        end
    end

    assign sum  = p ^ c[BYTE_W-1:0];
    assign cout = c[BYTE_W];

endmodule

// File: rtl/cla8_share_arb.sv
// rr_arb: NREQ-wide round-robin pick. The search starts at ptr and wraps,
// returning a one-hot grant, its encoded ID and an any-grant flag.
module rr_arb
    import cla8_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    // First requester at or above ptr (modulo NREQ) wins.
    always_comb begin
        logic [IDW-1:0] idx;
        // NOTE: every output gets a default before the search so no path
        // leaves it unassigned, which would infer a latch.
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/cla8_share_ctrl.sv
// cla8_share_ctrl: shares one cla8 between NREQ byte-serial requesters.
// A burst (LSB beat first) locks the adder to its owner; the carry is
// chained between beats in carry_q. Results leave through one registered
// valid/ready port tagged with the requester ID.
// Build option: define CLA8_SHARE_SUB_EN to honour req_sub (subtract as
// A + ~B + 1). Without it req_sub is ignored and every first beat adds
// with cin = 0.
module cla8_share_ctrl
    import cla8_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    input  logic [NREQ-1:0]      req_last,
    input  logic [NREQ-1:0]      req_sub,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [BYTE_W-1:0]    resp_sum,
    output logic                 resp_cout,
    output logic [IDW-1:0]       resp_id,
    output logic                 resp_last
);

    state_t          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  owner_q;
    logic            carry_q;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_id;
    logic            arb_any;

    logic            can_acc;
    logic            accept;
    logic [IDW-1:0]  sel_id;
    logic            sel_valid;
    logic [BYTE_W-1:0] a_arr [NREQ];
    logic [BYTE_W-1:0] b_arr [NREQ];
    logic [BYTE_W-1:0] op_a;
    logic [BYTE_W-1:0] op_b;
    logic [BYTE_W-1:0] b_eff;
    logic            op_last;
    logic            op_cin;
    logic            sub_now;
    logic [BYTE_W-1:0] add_sum;
    logic            add_cout;
    logic [IDW-1:0]  ptr_next;

`ifdef CLA8_SHARE_SUB_EN
    logic            sub_q;
`else
    logic            unused_sub;
    assign unused_sub = ^req_sub;
`endif

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    assign can_acc = !resp_valid || resp_ready;

    // Pick the active requester, gate acceptance and form the adder operands.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[i*BYTE_W +: BYTE_W];
            b_arr[i] = req_b[i*BYTE_W +: BYTE_W];
        end
        if (state_q == BURST) begin
            sel_id    = owner_q;
            sel_valid = req_valid[owner_q];
        end else begin
            sel_id    = arb_id;
            sel_valid = arb_any;
        end
        accept    = sel_valid && can_acc && !rst;
        req_ready = '0;
        if (accept) begin
            req_ready[sel_id] = 1'b1;
        end
        op_a    = a_arr[sel_id];
        op_b    = b_arr[sel_id];
        op_last = req_last[sel_id];
`ifdef CLA8_SHARE_SUB_EN
        sub_now = (state_q == BURST) ? sub_q : req_sub[sel_id];
`else
        sub_now = 1'b0;
`endif
        b_eff  = sub_now ? ~op_b : op_b;
        op_cin = (state_q == BURST) ? carry_q : sub_now;
        ptr_next = (int'(sel_id) == NREQ - 1) ? '0 : sel_id + 1'b1;
    end

    cla8 u_cla8 (
        .a    (op_a),
        .b    (b_eff),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Burst FSM, carry chain, pointer update and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the result data flops are reset too, so resp_* read as
            // zero out of reset rather than holding stale values.
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            carry_q    <= 1'b0;
`ifdef CLA8_SHARE_SUB_EN
            sub_q      <= 1'b0;
`endif
            resp_valid <= 1'b0;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
            resp_id    <= '0;
            resp_last  <= 1'b0;
        end else begin
            if (accept) begin
                resp_valid <= 1'b1;
                resp_sum   <= add_sum;
                resp_cout  <= add_cout;
                resp_id    <= sel_id;
                resp_last  <= op_last;
                carry_q    <= add_cout;
                if (op_last) begin
                    state_q <= IDLE;
                    ptr_q   <= ptr_next;
                end else if (state_q == IDLE) begin
                    state_q <= BURST;
                    owner_q <= arb_id;
`ifdef CLA8_SHARE_SUB_EN
                    sub_q   <= sub_now;
`endif
                end
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule
